am_demod_agc: RTL and testbench
===============================

// Module: am_demod_agc
// PURPOSE
//  Consumes the 8-bit signed filtered IF stream, one sample per clk, and envelope-detects it
//  by rectifying, integrating and decimating into an unsigned audio sample with a valid strobe.
//  Closes the AGC loop: peak-detects the envelope and drives the IF filter's 3-bit gain select
//  (0 = lowest gain, 5 = highest), with attack/hold/settle sequencing. Manual gain is selectable.
// PARAMETERS
//  DECIM_LOG2     6    log2 of input samples per audio sample (DECIM = 64)
//  AGC_WIN_LOG2   4    log2 of audio samples per AGC peak window (16)
//  HI_THRESH      112  peak magnitude above which gain is decremented (attack)
//  LO_THRESH      32   peak magnitude below which gain is incremented (release)
//  HOLD_WINDOWS   4    windows after a decrement during which increments are blocked
//  SETTLE_CYCLES  32   clks after a gain change during which peak tracking is suspended
//  GAIN_INIT      3    gain_sel value at reset
// PORTS
//  clk           in   1  system clock
//  RSTb          in   1  reset, synchronous, active-low
//  if_filt_in    in   8  signed filtered IF sample, valid every clk
//  agc_en        in   1  1 = AGC drives gain_sel; 0 = manual gain
//  gain_manual   in   3  manual gain request; values 6,7 clamp to 5
//  gain_sel      out  3  registered gain select to IF filter, range 0..5
//  audio_out     out  8  unsigned envelope sample, held between strobes
//  audio_valid   out  1  one-clk strobe: audio_out updated this cycle
//  agc_state     out  2  FSM state for debug: 0 ACQ, 1 DECIDE, 2 SETTLE
// BEHAVIOUR
//  Reset (RSTb=0 at clk edge): gain_sel=GAIN_INIT, audio_out=0, audio_valid=0, agc_state=ACQ;
//   mag, acc, sample/block/settle/hold counters and peak all 0. Reset mid-operation aborts all.
//  Stage 1: mag <= |if_filt_in|, 7 bits; -128 saturates to 127. Latency 1 clk.
//  Stage 2: acc (7+DECIM_LOG2 bits) adds mag each clk; sample counter 0..DECIM-1 wraps.
//   On count DECIM-1: audio_out <= (acc+mag) >> (DECIM_LOG2-1) (max 254, no overflow),
//   acc <= 0, audio_valid <= 1 next cycle only. Audio path runs regardless of FSM and agc_en.
//   First strobe is visible 65 clks after the first sample clocked in with RSTb=1.
//  FSM (only when agc_en=1):
//   ACQ: peak <= max(peak, mag) each clk; block counter increments on each audio strobe;
//    on the strobe completing block 2^AGC_WIN_LOG2 -> DECIDE.
//   DECIDE (1 clk), priority order:
//    peak > HI_THRESH and gain_sel>0 -> gain_sel-1, hold <= HOLD_WINDOWS;
//    else peak < LO_THRESH and hold==0 and gain_sel<5 -> gain_sel+1;
//    else no change, and hold decrements if nonzero.
//    Always clear peak and block counter. Gain changed -> SETTLE (counter=SETTLE_CYCLES) else ACQ.
//   SETTLE: peak and block counter frozen; counter decrements per clk; at 0 -> ACQ.
//  Boundaries: gain never wraps below 0 or above 5; peak==threshold causes no change.
//  agc_en=0: gain_sel <= min(gain_manual,5) every clk; FSM forced to ACQ; peak, block, settle
//   counters cleared; hold cleared. Deassert mid-SETTLE/DECIDE takes effect next clk.
//  agc_en 0->1: AGC starts from current gain_sel with a fresh ACQ window.
//  Strobe coinciding with SETTLE exit is not counted toward the new window.
// TESTING
//  1 Hold RSTb=0 3 clks -> gain_sel=3, audio_out=0, audio_valid=0, agc_state=0.
//  2 agc_en=0, gain_manual=7, input +64 constant -> gain_sel=5; audio_out=128 strobed every
//    64 clks, first strobe 65 clks after first sample.
//  3 agc_en=0, input -128 constant -> audio_out=254; alternating +100/-100 -> audio_out=200.
//  4 agc_en=1, input 120 constant from reset -> gain_sel 3->2 after 1024 samples + DECIDE,
//    SETTLE 32 clks, then ->1, ->0, then stays 0; agc_state sequence ACQ/DECIDE/SETTLE observed.
//  5 agc_en=1, input 10 constant from reset -> gain_sel 3->4->5, then holds at 5.
//    After forcing a decrement with 120, switch to 10 -> no increment for 4 windows, then +1.
//  6 agc_en dropped to 0 during SETTLE with gain_manual=1 -> gain_sel=1 and agc_state=ACQ
//    next clk; audio strobes continue uninterrupted at 64-clk spacing.

Source files
------------

// File: rtl/am_demod_agc_if.sv
// Signal bundle between the IF filter / control side and the AM envelope detector with AGC.
interface am_demod_agc_if;
  logic signed [7:0] if_filt_in;
  logic              agc_en;
  logic [2:0]        gain_manual;
  logic [2:0]        gain_sel;
  logic [7:0]        audio_out;
  logic              audio_valid;
  logic [1:0]        agc_state;

  modport master (
    output if_filt_in, agc_en, gain_manual,
    input  gain_sel, audio_out, audio_valid, agc_state
  );

  modport slave (
    input  if_filt_in, agc_en, gain_manual,
    output gain_sel, audio_out, audio_valid, agc_state
  );
endinterface

// File: rtl/am_demod_agc.sv
// AM envelope detector: rectify, integrate-and-dump decimation to an audio sample,
// plus a peak-driven AGC loop that steers the IF filter gain select.
module am_demod_agc #(
  parameter int DECIM_LOG2    = 6,
  parameter int AGC_WIN_LOG2  = 4,
  parameter int HI_THRESH     = 112,
  parameter int LO_THRESH     = 32,
  parameter int HOLD_WINDOWS  = 4,
  parameter int SETTLE_CYCLES = 32,
  parameter int GAIN_INIT     = 3
) (
  input  logic            clk,
  input  logic            RSTb,
  am_demod_agc_if.slave   bus
);
  localparam int ACC_W  = 7 + DECIM_LOG2;
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_WINDOWS + 1);

  localparam logic [6:0]        HI_T      = 7'(HI_THRESH);
  localparam logic [6:0]        LO_T      = 7'(LO_THRESH);
  localparam logic [2:0]        GAIN_MAX  = 3'd5;
  localparam logic [2:0]        GAIN_LD   = 3'(GAIN_INIT);
  localparam logic [SET_W-1:0]  SETTLE_LD = SET_W'(SETTLE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LD   = HOLD_W'(HOLD_WINDOWS);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_DECIDE = 2'd1,
    ST_SETTLE = 2'd2
  } agc_state_t;

  // Magnitude of a signed sample; -128 has no 7-bit magnitude so it saturates to 127.
  function automatic logic [6:0] abs_sat(input logic signed [7:0] x);
    logic [7:0] neg;
    neg = -x;
    if (!x[7])      return x[6:0];
    else if (neg[7]) return 7'd127;
    else            return neg[6:0];
  endfunction

  // Manual gain requests above the top step are pinned to the top step.
  function automatic logic [2:0] clamp_gain(input logic [2:0] g);
    return (g > GAIN_MAX) ? GAIN_MAX : g;
  endfunction

  // ---- stage p0: rectification ----
  logic [6:0] mag_p0;
  logic       vld_p0;

  // Register the rectified sample; vld_p0 marks that a real sample has entered the pipe.
  always_ff @(posedge clk) begin
    if (!RSTb) begin
      mag_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      mag_p0 <= abs_sat(bus.if_filt_in);
      vld_p0 <= 1'b1;
    end
  end

  // ---- stage p1: integrate and dump ----
  logic [ACC_W-1:0]      acc_p1;
  logic [ACC_W-1:0]      acc_sum;
  logic [DECIM_LOG2-1:0] samp_cnt;
  logic [7:0]            audio_p1;
  logic                  vld_p1;

  assign acc_sum = acc_p1 + ACC_W'(mag_p0);

  // Sum DECIM magnitudes, then emit the scaled sum and restart the accumulator.
  always_ff @(posedge clk) begin
    if (!RSTb) begin
      acc_p1   <= '0;
      samp_cnt <= '0;
      audio_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (vld_p0) begin
        samp_cnt <= samp_cnt + 1'b1;
        if (&samp_cnt) begin
          audio_p1 <= acc_sum[ACC_W-1:DECIM_LOG2-1];
          acc_p1   <= '0;
          vld_p1   <= 1'b1;
        end else begin
          acc_p1 <= acc_sum;
        end
      end
    end
  end

  // ---- AGC loop ----
  agc_state_t              state, state_nx;
  logic [6:0]              peak, peak_nx;
  logic [AGC_WIN_LOG2-1:0] blk_cnt, blk_nx;
  logic [SET_W-1:0]        settle_cnt, settle_nx;
  logic [HOLD_W-1:0]       hold_cnt, hold_nx;
  logic [2:0]              gain, gain_nx;

  // AGC state register; reset restarts acquisition at the initial gain.
  always_ff @(posedge clk) begin
    if (!RSTb) begin
      state      <= ST_ACQ;
      peak       <= '0;
      blk_cnt    <= '0;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      gain       <= GAIN_LD;
    end else begin
      state      <= state_nx;
      peak       <= peak_nx;
      blk_cnt    <= blk_nx;
      settle_cnt <= settle_nx;
      hold_cnt   <= hold_nx;
      gain       <= gain_nx;
    end
  end

  // Next-state logic: manual override, peak acquisition, gain decision, settling.
  always_comb begin
    state_nx  = state;
    peak_nx   = peak;
    blk_nx    = blk_cnt;
    settle_nx = settle_cnt;
    hold_nx   = hold_cnt;
    gain_nx   = gain;
    if (!bus.agc_en) begin
      state_nx  = ST_ACQ;
      peak_nx   = '0;
      blk_nx    = '0;
      settle_nx = '0;
      hold_nx   = '0;
      gain_nx   = clamp_gain(bus.gain_manual);
    end else begin
      unique case (state)
        ST_ACQ: begin
          if (mag_p0 > peak) peak_nx = mag_p0;
          if (vld_p1) begin
            blk_nx = blk_cnt + 1'b1;
            if (&blk_cnt) state_nx = ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          peak_nx = '0;
          blk_nx  = '0;
          if (peak > HI_T && gain != '0) begin
            gain_nx   = gain - 1'b1;
            hold_nx   = HOLD_LD;
            settle_nx = SETTLE_LD;
            state_nx  = ST_SETTLE;
          end else if (peak < LO_T && hold_cnt == '0 && gain < GAIN_MAX) begin
            gain_nx   = gain + 1'b1;
            settle_nx = SETTLE_LD;
            state_nx  = ST_SETTLE;
          end else begin
            state_nx = ST_ACQ;
            if (hold_cnt != '0) hold_nx = hold_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state_nx = ST_ACQ;
          else                  settle_nx = settle_cnt - 1'b1;
        end
        default: state_nx = ST_ACQ;
      endcase
    end
  end

  assign bus.gain_sel    = gain;
  assign bus.audio_out   = audio_p1;
  assign bus.audio_valid = vld_p1;
  assign bus.agc_state   = state;
endmodule

// File: tb/tb_am_demod_agc.sv
// Bench for am_demod_agc: random-sign stimulus at chosen magnitudes, a block-sum
// audio model and a window-level AGC decision model.
module tb_am_demod_agc;
  logic clk = 1'b0;
  logic RSTb;

  am_demod_agc_if bus();

  am_demod_agc dut (
    .clk  (clk),
    .RSTb (RSTb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (sample %0d)", tag, got, exp, e);
    end
  endtask

  // stimulus controls
  logic       en;
  logic [2:0] man;
  int         mode;      // 0: +/-level, 1: uniform random, 2: alternating +100/-100
  int         level;
  int         lvl_q[$];

  // reference model state
  int  e;                      // samples clocked in since reset release
  int  mag_hist [0:65535];
  int  m_audio;
  int  m_gain, m_hold, m_win;
  bit  pend_strobe;
  int  dec_e;
  bit  dec_chg, dec_track;

  function automatic int smag(input int v);
    if (v < 0) return (-v > 127) ? 127 : -v;
    return v;
  endfunction

  // One AGC window boundary per 16 strobes seen while AGC is enabled.
  task automatic agc_strobe();
    int pk;
    int old;
    m_win++;
    if (m_win == 16) begin
      pk = 0;
      for (int k = e - 63; k <= e; k++) if (mag_hist[k] > pk) pk = mag_hist[k];
      old = m_gain;
      if (pk > 112 && m_gain > 0) begin
        m_gain--;
        m_hold = 4;
      end else if (pk < 32 && m_hold == 0 && m_gain < 5) begin
        m_gain++;
      end else if (m_hold > 0) begin
        m_hold--;
      end
      m_win     = 0;
      dec_e     = e;
      dec_chg   = (m_gain != old);
      dec_track = 1'b1;
      if (lvl_q.size() > 0) level = lvl_q.pop_front();
    end
  endtask

  task automatic observe();
    bit exp_v;
    int s;
    exp_v = (e > 1) && ((e - 1) % 64 == 0);
    check("audio_valid", int'(bus.audio_valid), int'(exp_v));
    if (exp_v) begin
      s = 0;
      for (int k = e - 64; k <= e - 1; k++) s += mag_hist[k];
      m_audio = s >> 5;
      check("gain_at_strobe", int'(bus.gain_sel), m_gain);
    end
    check("audio_out", int'(bus.audio_out), m_audio);
    if (dec_track) begin
      if (e == dec_e + 1) check("state_decide", int'(bus.agc_state), 1);
      if (e == dec_e + 2) begin
        check("state_after_decide", int'(bus.agc_state), dec_chg ? 2 : 0);
        check("gain_after_decide", int'(bus.gain_sel), m_gain);
      end
      if (e == dec_e + 20) check("state_mid_settle", int'(bus.agc_state), dec_chg ? 2 : 0);
      if (e == dec_e + 40) begin
        check("state_back_acq", int'(bus.agc_state), 0);
        dec_track = 1'b0;
      end
    end
    pend_strobe = exp_v;
  endtask

  task automatic step();
    int v;
    case (mode)
      0:       v = ($urandom_range(0, 1) != 0) ? level : -level;
      1:       v = int'($urandom_range(0, 255)) - 128;
      default: v = (e % 2 != 0) ? 100 : -100;
    endcase
    if (v == 128) v = -128;
    bus.if_filt_in  = 8'(v);
    bus.agc_en      = en;
    bus.gain_manual = man;
    if (!en) begin
      m_gain    = (int'(man) > 5) ? 5 : int'(man);
      m_hold    = 0;
      m_win     = 0;
      dec_track = 1'b0;
    end else if (pend_strobe) begin
      agc_strobe();
    end
    pend_strobe = 1'b0;
    @(posedge clk);
    #1;
    e++;
    mag_hist[e] = smag(v);
    observe();
  endtask

  task automatic do_reset();
    RSTb            = 1'b0;
    bus.if_filt_in  = '0;
    bus.agc_en      = en;
    bus.gain_manual = man;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gain_sel", int'(bus.gain_sel), 3);
    check("rst_audio_out", int'(bus.audio_out), 0);
    check("rst_audio_valid", int'(bus.audio_valid), 0);
    check("rst_agc_state", int'(bus.agc_state), 0);
    RSTb        = 1'b1;
    e           = 0;
    m_audio     = 0;
    m_gain      = 3;
    m_hold      = 0;
    m_win       = 0;
    pend_strobe = 1'b0;
    dec_track   = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int nsteps;
    dec_e = -1000;

    // manual gain, constant and patterned inputs
    en = 1'b0; man = 3'd7; mode = 0; level = 64;
    do_reset();
    repeat (200) step();
    check("manual_clamp_gain", int'(bus.gain_sel), 5);
    level = 128;
    repeat (128) step();
    mode = 2;
    repeat (128) step();
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      man = 3'($urandom_range(0, 7));
      repeat (50) step();
    end

    // AGC from a mid-run reset: release to the top, attack to the bottom, hold-off, thresholds
    en = 1'b1; man = 3'd0; mode = 0; level = 10;
    lvl_q = {10, 10, 120, 120, 120, 120, 10, 10, 10, 10, 10,
             112, 32, 113, 31, 31, 31, 31, 31, 128, 120, 120};
    for (int i = 0; i < 3; i++) lvl_q.push_back(int'($urandom_range(0, 128)));
    nsteps = (lvl_q.size() + 1) * 1024 + 100;
    do_reset();
    repeat (nsteps) step();

    // manual gain 4, then AGC; drop AGC while settling
    en = 1'b0; man = 3'd4; level = 120;
    repeat (100) step();
    check("manual_gain_4", int'(bus.gain_sel), 4);
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step();
      if (dec_track && dec_chg && e == dec_e + 5) found = 1'b1;
    end
    check("settle_reached", int'(found), 1);
    if (found) begin
      check("state_before_drop", int'(bus.agc_state), 2);
      en = 1'b0; man = 3'd1;
      step();
      check("drop_gain_sel", int'(bus.gain_sel), 1);
      check("drop_agc_state", int'(bus.agc_state), 0);
    end
    repeat (300) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
